line_buf_ctrl: RTL and testbench
================================

LINE_BUF_CTRL -- requirements
Module: line_buf_ctrl

Interface
REQ-001 SHALL have parameter IMG_WIDTH, default 540, pixels per image row (legal range 3 or more).
REQ-002 SHALL have parameter IMG_HEIGHT, default 540, rows per frame (legal range 3 or more).
REQ-003 SHALL have parameter CW, default $clog2(max(IMG_WIDTH, IMG_HEIGHT)), width of the coordinate outputs.
REQ-004 clock  input  1  sole clock; all state updates on its rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset (asserted at 0).
REQ-006 start  input  1  begin a frame; sampled only in IDLE.
REQ-007 in_valid  input  1  upstream pixel valid.
REQ-008 in_pixel  input  8  upstream pixel, raster order.
REQ-009 in_ready  output  1  pixel accepted when in_valid and in_ready are both high.
REQ-010 sr_shift_en  output  1  shift enable to the 3x3 line-buffer shift register.
REQ-011 sr_pixel  output  8  pixel written into the line buffer.
REQ-012 win_valid  output  1  line-buffer window output currently holds a complete, non-wrapping 3x3 window.
REQ-013 win_row  output  CW  row of the window centre pixel.
REQ-014 win_col  output  CW  column of the window centre pixel.
REQ-015 out_ready  input  1  downstream consumer accepts the window this cycle.
REQ-016 busy  output  1  high in any state other than IDLE.
REQ-017 frame_done  output  1  one-cycle pulse at end of frame.

Function
REQ-018 FSM states SHALL be IDLE, STREAM and DRAIN.
REQ-019 Transition IDLE->STREAM SHALL occur on start=1; on entry, the column and row counters SHALL be 0.
REQ-020 start SHALL be ignored in STREAM and DRAIN.
REQ-021 in_ready SHALL be combinational: (state==STREAM) and not (win_valid and not out_ready).
REQ-022 sr_shift_en SHALL equal in_valid and in_ready; sr_pixel SHALL equal in_pixel, combinationally.
REQ-023 Each accepted pixel k SHALL have position r=k/IMG_WIDTH and c=k%IMG_WIDTH, tracked by a column counter that wraps at IMG_WIDTH-1 and increments the row counter on wrap.
REQ-024 When accepted pixel (r,c) has r>=2 and c>=2, the next cycle SHALL have win_valid=1, win_row=r-1 and win_col=c-1 (one-cycle latency, matching the line-buffer register).
REQ-025 Accepted pixels with r<2 or c<2 SHALL NOT raise win_valid; such windows either prime the buffer or straddle a row boundary.
REQ-026 win_valid SHALL clear after a cycle with out_ready=1, unless a new qualifying pixel is accepted in that same cycle, in which case it stays 1 with the updated coordinates.
REQ-027 While win_valid=1 and out_ready=0, in_ready SHALL be 0, so the line buffer does not shift and the window, win_row and win_col hold stable.
REQ-028 Acceptance of the last pixel (r=IMG_HEIGHT-1, c=IMG_WIDTH-1) SHALL move the FSM to DRAIN; in_ready SHALL be 0 in DRAIN.
REQ-029 In DRAIN, once win_valid is 0 or is being accepted (out_ready=1), the FSM SHALL return to IDLE and frame_done SHALL pulse high for exactly that cycle.
REQ-030 Pixels SHALL NOT be accepted outside STREAM; in_valid outside STREAM SHALL have no effect.
REQ-031 Counters SHALL hold when no pixel is accepted (in_valid gaps).

Reset
REQ-032 reset=0 SHALL asynchronously force state IDLE, both counters 0, win_valid 0, win_row 0, win_col 0 and frame_done 0; consequently in_ready, sr_shift_en and busy SHALL be 0.
REQ-033 Reset mid-frame SHALL abandon the frame with no frame_done pulse; the next frame requires a new start.
REQ-034 Line-buffer contents are not cleared by this block; stale data SHALL never be flagged valid because of the priming rule in REQ-025.

Verification (IMG_WIDTH=4, IMG_HEIGHT=4)
REQ-035 Reset: assert reset=0 with in_valid=1 and start=1 -> all outputs 0, busy 0; they remain 0 until reset=1 and a start is applied.
REQ-036 Full frame: start, then 16 back-to-back pixels with out_ready=1 -> win_valid high the cycle after pixels k=10, 11, 14 and 15 with (row,col) = (1,1), (1,2), (2,1), (2,2); frame_done pulses once; busy falls the cycle after.
REQ-037 Backpressure: out_ready=0 when window (1,1) appears -> in_ready=0 and sr_shift_en=0, and win_row/win_col hold (1,1) for the stall; raise out_ready -> the next pixel is accepted that cycle.
REQ-038 Gaps: in_valid toggled 1,0,0,1 -> only 2 shifts; the counters advance by 2 and win_valid timing follows the accepted pixels only.
REQ-039 Ignored start and mid-frame reset: start pulse during STREAM -> counters unaffected; reset=0 after pixel 7 -> IDLE with no frame_done, and a new start restarts at (0,0).
REQ-040 Drain stall: last pixel accepted with out_ready=0 -> FSM in DRAIN with win_valid held at (2,2); frame_done is delayed until out_ready=1, then pulses exactly once.

Source files
------------

// File: rtl/line_buf_ctrl.sv
// line_buf_ctrl: raster-order pixel controller for a 3x3 line-buffer window.
// Tracks the (row,col) of every accepted pixel, drives the line-buffer shift
// enable, flags complete non-wrapping windows with one cycle of latency and
// holds them under downstream backpressure.

module line_buf_ctrl #(
  parameter int IMG_WIDTH  = 540,
  parameter int IMG_HEIGHT = 540,
  parameter int CW         = $clog2((IMG_WIDTH > IMG_HEIGHT) ? IMG_WIDTH : IMG_HEIGHT)
) (
  input  logic          i_clock,
  input  logic          i_reset_n,
  input  logic          i_start,
  input  logic          i_in_valid,
  input  logic [7:0]    i_in_pixel,
  output logic          o_in_ready,
  output logic          o_sr_shift_en,
  output logic [7:0]    o_sr_pixel,
  output logic          o_win_valid,
  output logic [CW-1:0] o_win_row,
  output logic [CW-1:0] o_win_col,
  input  logic          i_out_ready,
  output logic          o_busy,
  output logic          o_frame_done
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DRAIN  = 2'd2
  } state_t;

  localparam logic [CW-1:0] LAST_COL = CW'(IMG_WIDTH - 1);
  localparam logic [CW-1:0] LAST_ROW = CW'(IMG_HEIGHT - 1);
  localparam logic [CW-1:0] ONE      = CW'(1);
  localparam logic [CW-1:0] TWO      = CW'(2);

  state_t        r_state;
  state_t        w_next_state;
  logic [CW-1:0] r_col;
  logic [CW-1:0] r_row;
  logic          r_win_valid;
  logic [CW-1:0] r_win_row;
  logic [CW-1:0] r_win_col;

  logic w_in_ready;
  logic w_accept;
  logic w_last_col;
  logic w_last_pixel;
  logic w_qualify;
  logic w_drain_exit;

  // Handshake and position decode: a held window blocks the line buffer so
  // the window contents cannot move underneath the consumer.
  always_comb begin
    w_in_ready   = (r_state == STREAM) && !(r_win_valid && !i_out_ready);
    w_accept     = i_in_valid && w_in_ready;
    w_last_col   = (r_col == LAST_COL);
    w_last_pixel = w_last_col && (r_row == LAST_ROW);
    w_qualify    = w_accept && (r_row >= TWO) && (r_col >= TWO);
    w_drain_exit = (r_state == DRAIN) && (!r_win_valid || i_out_ready);
  end

  // Next-state logic: the frame ends once the last pixel is taken and the
  // final window has been handed off.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (i_start) w_next_state = STREAM;
      STREAM:  if (w_accept && w_last_pixel) w_next_state = DRAIN;
      DRAIN:   if (w_drain_exit) w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Raster position counters; parked at zero in IDLE so every frame starts at (0,0).
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_col <= '0;
      r_row <= '0;
    end else if (r_state == IDLE) begin
      r_col <= '0;
      r_row <= '0;
    end else if (w_accept) begin
      if (w_last_col) begin
        r_col <= '0;
        r_row <= w_last_pixel ? '0 : (r_row + ONE);
      end else begin
        r_col <= r_col + ONE;
      end
    end
  end

  // Window flag and centre coordinates, one cycle behind the accepted pixel;
  // priming pixels (first two rows/cols) never raise the flag.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_win_valid <= 1'b0;
      r_win_row   <= '0;
      r_win_col   <= '0;
    end else if (w_qualify) begin
      r_win_valid <= 1'b1;
      r_win_row   <= r_row - ONE;
      r_win_col   <= r_col - ONE;
    end else if (i_out_ready) begin
      r_win_valid <= 1'b0;
    end
  end

  assign o_in_ready    = w_in_ready;
  assign o_sr_shift_en = w_accept;
  assign o_sr_pixel    = i_in_pixel;
  assign o_win_valid   = r_win_valid;
  assign o_win_row     = r_win_row;
  assign o_win_col     = r_win_col;
  assign o_busy        = (r_state != IDLE);
  assign o_frame_done  = w_drain_exit;

endmodule

// File: tb/tb_line_buf_ctrl.sv
// tb_line_buf_ctrl: 4x4 frame bench for line_buf_ctrl with a pixel-count
// reference model; outputs are compared on the falling edge of every cycle.

module tb_line_buf_ctrl;

  localparam int W    = 4;
  localparam int H    = 4;
  localparam int CW   = 2;
  localparam int NPIX = W * H;

  logic          clk = 1'b0;
  logic          rstN = 1'b0;
  logic          start = 1'b0;
  logic          inValid = 1'b0;
  logic [7:0]    inPixel = 8'd0;
  logic          outReady = 1'b0;
  logic          inReady;
  logic          shiftEn;
  logic [7:0]    srPixel;
  logic          winValid;
  logic [CW-1:0] winRow;
  logic [CW-1:0] winCol;
  logic          busy;
  logic          frameDone;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: a frame is either inactive, taking pixels, or waiting
  // for its final window to be consumed.
  bit mFrameActive = 1'b0;
  bit mAllTaken    = 1'b0;
  int mCount       = 0;
  bit mWinValid    = 1'b0;
  int mWinRow      = 0;
  int mWinCol      = 0;

  int dutDoneCount  = 0;
  int dutWinCycles  = 0;
  bit recordWins    = 1'b0;
  int winRowsSeen[$];
  int winColsSeen[$];

  line_buf_ctrl #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .CW(CW)) dut (
    .i_clock      (clk),
    .i_reset_n    (rstN),
    .i_start      (start),
    .i_in_valid   (inValid),
    .i_in_pixel   (inPixel),
    .o_in_ready   (inReady),
    .o_sr_shift_en(shiftEn),
    .o_sr_pixel   (srPixel),
    .o_win_valid  (winValid),
    .o_win_row    (winRow),
    .o_win_col    (winCol),
    .i_out_ready  (outReady),
    .o_busy       (busy),
    .o_frame_done (frameDone)
  );

  // 10-time-unit clock.
  always #5 clk = ~clk;

  function automatic bit modelReady();
    return mFrameActive && !mAllTaken && !(mWinValid && !outReady);
  endfunction

  function automatic bit modelDone();
    return mFrameActive && mAllTaken && (!mWinValid || outReady);
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic flagTimeout(input string tag);
    vectors++;
    miscompares++;
    $error("[TB] FAIL %s: cycle budget expired at pixel count %0d", tag, mCount);
  endtask

  task automatic applyStimulus(input bit s, input bit v, input logic [7:0] p, input bit o);
    start    = s;
    inValid  = v;
    inPixel  = p;
    outReady = o;
  endtask

  task automatic resetModel();
    mFrameActive = 1'b0;
    mAllTaken    = 1'b0;
    mCount       = 0;
    mWinValid    = 1'b0;
    mWinRow      = 0;
    mWinCol      = 0;
  endtask

  task automatic checkAll();
    bit expReady;
    expReady = modelReady();
    checkOutput("in_ready", inReady, expReady);
    checkOutput("sr_shift_en", shiftEn, inValid && expReady);
    checkOutput("sr_pixel", srPixel, inPixel);
    checkOutput("win_valid", winValid, mWinValid);
    if (mWinValid) begin
      checkOutput("win_row", winRow, 32'(mWinRow));
      checkOutput("win_col", winCol, 32'(mWinCol));
    end
    checkOutput("frame_done", frameDone, modelDone());
    checkOutput("busy", busy, mFrameActive);
    if (frameDone) dutDoneCount++;
    if (winValid) begin
      dutWinCycles++;
      if (recordWins) begin
        winRowsSeen.push_back(int'(winRow));
        winColsSeen.push_back(int'(winCol));
      end
    end
  endtask

  // Advance the model by one clock using the inputs held during the cycle.
  task automatic updateModel();
    bit acc;
    bit done;
    bit qual;
    int r;
    int c;
    acc  = inValid && modelReady();
    done = modelDone();
    qual = 1'b0;
    if (!mFrameActive) begin
      if (start) begin
        mFrameActive = 1'b1;
        mAllTaken    = 1'b0;
        mCount       = 0;
      end
    end else if (!mAllTaken && acc) begin
      r = mCount / W;
      c = mCount % W;
      if (r >= 2 && c >= 2) begin
        qual    = 1'b1;
        mWinRow = r - 1;
        mWinCol = c - 1;
      end
      mCount++;
      if (mCount == NPIX) mAllTaken = 1'b1;
    end
    if (qual) mWinValid = 1'b1;
    else if (outReady) mWinValid = 1'b0;
    if (done) mFrameActive = 1'b0;
  endtask

  task automatic stepCycle();
    @(negedge clk);
    checkAll();
    @(posedge clk);
    updateModel();
    #1;
  endtask

  task automatic resetCycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      checkAll();
      @(posedge clk);
      #1;
    end
  endtask

  // Drive random pixels until the model reaches stopCount accepted pixels,
  // or (stopCount==0) until the frame finishes.
  task automatic runPixels(input int stopCount, input int validPct, input int readyPct,
                           input int startPct, input int budget, input string tag);
    int n;
    n = 0;
    while ((stopCount == 0) ? mFrameActive : (mCount < stopCount)) begin
      if (n >= budget) begin
        flagTimeout(tag);
        break;
      end
      applyStimulus(($urandom_range(99) < startPct), ($urandom_range(99) < validPct),
                    8'($urandom), ($urandom_range(99) < readyPct));
      stepCycle();
      n++;
    end
  endtask

  task automatic startFrame();
    applyStimulus(1'b1, 1'b0, 8'h00, 1'b1);
    stepCycle();
    start = 1'b0;
  endtask

  initial begin
    int baseDone;
    int baseWin;
    int expRows[4] = '{1, 1, 2, 2};
    int expCols[4] = '{1, 2, 1, 2};

    // Reset held with start and in_valid active: everything stays quiet.
    rstN = 1'b0;
    applyStimulus(1'b1, 1'b1, 8'hA5, 1'b1);
    resetModel();
    resetCycles(3);
    @(posedge clk);
    #1;
    rstN = 1'b1;
    applyStimulus(1'b0, 1'b1, 8'h3C, 1'b1);
    stepCycle();
    stepCycle();

    // Full frame, back-to-back pixels, consumer always ready.
    baseDone = dutDoneCount;
    baseWin  = dutWinCycles;
    winRowsSeen.delete();
    winColsSeen.delete();
    recordWins = 1'b1;
    startFrame();
    runPixels(0, 100, 100, 0, 60, "full_frame");
    recordWins = 1'b0;
    checkOutput("full_done_count", dutDoneCount - baseDone, 1);
    checkOutput("full_win_cycles", dutWinCycles - baseWin, 4);
    checkOutput("full_win_list_len", winRowsSeen.size(), 4);
    for (int i = 0; i < 4 && i < winRowsSeen.size(); i++) begin
      checkOutput("full_win_row", winRowsSeen[i], expRows[i]);
      checkOutput("full_win_col", winColsSeen[i], expCols[i]);
    end
    applyStimulus(1'b0, 1'b1, 8'h11, 1'b1);
    stepCycle();
    checkOutput("busy_after_frame", busy, 1'b0);

    // Backpressure: consumer stalls on the first window, then resumes.
    startFrame();
    runPixels(11, 100, 0, 0, 60, "bp_fill");
    applyStimulus(1'b0, 1'b1, 8'h77, 1'b0);
    for (int i = 0; i < 3; i++) stepCycle();
    @(negedge clk);
    checkOutput("bp_stall_ready", inReady, 1'b0);
    checkOutput("bp_stall_row", winRow, 32'd1);
    checkOutput("bp_stall_col", winCol, 32'd1);
    @(posedge clk);
    #1;
    applyStimulus(1'b0, 1'b1, 8'h78, 1'b1);
    @(negedge clk);
    checkOutput("bp_resume_shift", shiftEn, 1'b1);
    @(posedge clk);
    updateModel();
    #1;
    runPixels(0, 100, 100, 0, 60, "bp_finish");

    // Valid gaps 1,0,0,1 and start pulses during streaming.
    startFrame();
    applyStimulus(1'b0, 1'b1, 8'h01, 1'b1); stepCycle();
    applyStimulus(1'b1, 1'b0, 8'h02, 1'b1); stepCycle();
    applyStimulus(1'b0, 1'b0, 8'h03, 1'b1); stepCycle();
    applyStimulus(1'b1, 1'b1, 8'h04, 1'b1); stepCycle();
    checkOutput("gap_count", mCount, 2);
    runPixels(8, 60, 100, 50, 100, "gap_fill");

    // Mid-frame reset after pixel 7: no frame_done, restart from (0,0).
    baseDone = dutDoneCount;
    @(posedge clk);
    rstN = 1'b0;
    resetModel();
    applyStimulus(1'b1, 1'b1, 8'hEE, 1'b1);
    resetCycles(2);
    checkOutput("mid_reset_no_done", dutDoneCount - baseDone, 0);
    rstN = 1'b1;
    applyStimulus(1'b0, 1'b1, 8'h10, 1'b1);
    stepCycle();
    startFrame();
    runPixels(0, 100, 100, 0, 60, "restart_frame");
    checkOutput("restart_done_count", dutDoneCount - baseDone, 1);

    // Drain stall: last pixel taken with the consumer stalled.
    baseDone = dutDoneCount;
    startFrame();
    runPixels(15, 100, 100, 0, 60, "drain_fill");
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b1); stepCycle();
    applyStimulus(1'b0, 1'b1, 8'hF0, 1'b0); stepCycle();
    applyStimulus(1'b0, 1'b1, 8'hF1, 1'b0);
    for (int i = 0; i < 3; i++) stepCycle();
    @(negedge clk);
    checkOutput("drain_hold_valid", winValid, 1'b1);
    checkOutput("drain_hold_row", winRow, 32'd2);
    checkOutput("drain_hold_col", winCol, 32'd2);
    checkOutput("drain_no_done", dutDoneCount - baseDone, 0);
    @(posedge clk);
    updateModel();
    #1;
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b1);
    stepCycle();
    stepCycle();
    checkOutput("drain_done_count", dutDoneCount - baseDone, 1);

    // Randomized frames with random valid, ready and start activity.
    for (int f = 0; f < 6; f++) begin
      baseDone = dutDoneCount;
      startFrame();
      runPixels(0, 70, 60, 30, 600, "random_frame");
      checkOutput("random_done_count", dutDoneCount - baseDone, 1);
      applyStimulus(1'b0, 1'b1, 8'h5A, 1'b0);
      stepCycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
